// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - iterative AES-128 key expansion, one round key per handshake; optional round-key cache under AES_KEY_CACHE_EN

// AES S-box computed as GF(2^8) inverse (a^254) followed by the affine transform.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Addition chain for a^254 (254 = 240 + 12 + 2); zero maps to zero on its own.
  assign x2   = gf_mul(a, a);
  assign x3   = gf_mul(x2, a);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  // Affine transform: XOR of the inverse with its four left rotations, plus 0x63.
  assign s = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;

endmodule

module aes_key_sched #(
  parameter int RND_SIZE = 128,
  parameter int WRD_SIZE = 32,
  parameter int NUM_BLK  = 4,
  parameter int NUM_RND  = 10,
  parameter int CNT_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_key_vld,
  input  logic [RND_SIZE-1:0] i_key,
  output logic                o_key_rdy,
  output logic                o_rk_vld,
  input  logic                i_rk_rdy,
  output logic [RND_SIZE-1:0] o_rk,
  output logic [CNT_SIZE-1:0] o_rk_idx,
  output logic                o_rk_last,
  input  logic                i_replay
);

  localparam logic [CNT_SIZE-1:0] LAST_IDX = CNT_SIZE'(NUM_RND);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [7:0]          rcon;
  logic                key_acc;
  logic                rpl_acc;
  logic                rpl_ok;
  logic                rk_adv;
  logic [CNT_SIZE-1:0] idx_inc;
  logic [WRD_SIZE-1:0] w_last;
  logic [WRD_SIZE-1:0] rot_w;
  logic [WRD_SIZE-1:0] sub_w;
  logic [WRD_SIZE-1:0] t_w;
  logic [WRD_SIZE-1:0] acc;
  logic [RND_SIZE-1:0] rk_gen;
  logic [RND_SIZE-1:0] rk_nxt;
  logic [RND_SIZE-1:0] rpl_key;

  assign idx_inc = o_rk_idx + CNT_SIZE'(1);

  // SubWord(RotWord(w3)) ^ rcon, where w3 is the least significant word of the current key.
  assign w_last = o_rk[WRD_SIZE-1:0];
  assign rot_w  = {w_last[WRD_SIZE-9:0], w_last[WRD_SIZE-1 -: 8]};

  for (genvar g = 0; g < WRD_SIZE / 8; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot_w[g*8 +: 8]),
      .s (sub_w[g*8 +: 8])
    );
  end

  assign t_w = sub_w ^ {rcon, {(WRD_SIZE-8){1'b0}}};

  // Chained word XOR: n0 = w0^t, n(i) = w(i)^n(i-1), word 0 in the MSBs.
  always_comb begin
    rk_gen = '0;
    acc    = t_w;
    for (int i = 0; i < NUM_BLK; i++) begin
      acc = acc ^ o_rk[RND_SIZE-1-i*WRD_SIZE -: WRD_SIZE];
      rk_gen[RND_SIZE-1-i*WRD_SIZE -: WRD_SIZE] = acc;
    end
  end

`ifdef AES_KEY_CACHE_EN
  logic [RND_SIZE-1:0] cache [0:NUM_RND];
  logic                cache_vld;
  logic                rpl_mode;

  assign rpl_ok  = i_replay & cache_vld;
  assign rpl_key = cache[0];
  assign rk_nxt  = rpl_mode ? cache[idx_inc] : rk_gen;

  // Register file captures every generated key; entry 0 is the cipher key itself.
  always_ff @(posedge clk) begin
    if (key_acc)
      cache[0] <= i_key;
    else if (rk_adv && !rpl_mode)
      cache[idx_inc] <= rk_gen;
  end

  // Cache becomes valid only once the final round key has been generated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld <= 1'b0;
      rpl_mode  <= 1'b0;
    end else if (key_acc) begin
      cache_vld <= 1'b0;
      rpl_mode  <= 1'b0;
    end else if (rpl_acc) begin
      rpl_mode  <= 1'b1;
    end else if (rk_adv && !rpl_mode && (idx_inc == LAST_IDX)) begin
      cache_vld <= 1'b1;
    end
  end
`else
  logic unused_replay;

  assign unused_replay = i_replay;
  assign rpl_ok        = 1'b0;
  assign rpl_key       = '0;
  assign rk_nxt        = rk_gen;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake decode; a new cipher key wins over replay.
  always_comb begin
    state_nxt = state;
    o_key_rdy = 1'b0;
    key_acc   = 1'b0;
    rpl_acc   = 1'b0;
    rk_adv    = 1'b0;
    case (state)
      IDLE: begin
        o_key_rdy = 1'b1;
        if (i_key_vld) begin
          key_acc   = 1'b1;
          state_nxt = RUN;
        end else if (rpl_ok) begin
          rpl_acc   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_rk_rdy) begin
          if (o_rk_idx == LAST_IDX) state_nxt = IDLE;
          else                      rk_adv    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_rk_vld  = (state == RUN);
  assign o_rk_last = o_rk_vld & (o_rk_idx == LAST_IDX);

  // Round-key register, index and rcon; held while stalled and after the last key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rk     <= '0;
      o_rk_idx <= '0;
      rcon     <= 8'h01;
    end else if (key_acc) begin
      o_rk     <= i_key;
      o_rk_idx <= '0;
      rcon     <= 8'h01;
    end else if (rpl_acc) begin
      o_rk     <= rpl_key;
      o_rk_idx <= '0;
      rcon     <= 8'h01;
    end else if (rk_adv) begin
      o_rk     <= rk_nxt;
      o_rk_idx <= idx_inc;
      rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// tb/tb_aes_key_sched.sv - scoreboard testbench for aes_key_sched
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_key_vld = 1'b0;
  logic [127:0] i_key = '0;
  logic         i_rk_rdy = 1'b0;
  logic         i_replay = 1'b0;
  logic         o_key_rdy;
  logic         o_rk_vld;
  logic [127:0] o_rk;
  logic [3:0]   o_rk_idx;
  logic         o_rk_last;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] rk;
    logic [3:0]   idx;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model_rk [0:10];
  logic [127:0] last_key;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;
  localparam logic [127:0] KEY_C1   = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  always #5 clk = ~clk;

  aes_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_key_vld (i_key_vld),
    .i_key     (i_key),
    .o_key_rdy (o_key_rdy),
    .o_rk_vld  (o_rk_vld),
    .i_rk_rdy  (i_rk_rdy),
    .o_rk      (o_rk),
    .o_rk_idx  (o_rk_idx),
    .o_rk_last (o_rk_last),
    .i_replay  (i_replay)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] yv;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++) begin
      yv = y[7:0];
      if (gmul(x, yv) == 8'h01) inv = yv;
    end
    for (int i = 0; i < 8; i++)
      b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return b;
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0]), sbox_ref(t[31:24])} ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_stream(input logic [127:0] k);
    exp_t e;
    expand(k);
    for (int r = 0; r < 11; r++) begin
      e.rk  = model_rk[r];
      e.idx = r[3:0];
      sb.push_back(e);
    end
  endtask

  task automatic send_key(input logic [127:0] k);
    @(negedge clk);
    i_key     = k;
    i_key_vld = 1'b1;
    @(negedge clk);
    i_key_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_key_rdy !== 1'b1) begin failures++; $display("FAIL reset_key_rdy got=%0b exp=1", o_key_rdy); end
    checks++; if (o_rk_vld !== 1'b0) begin failures++; $display("FAIL reset_rk_vld got=%0b exp=0", o_rk_vld); end
    checks++; if (o_rk !== 128'h0) begin failures++; $display("FAIL reset_rk got=%h exp=0", o_rk); end
    checks++; if (o_rk_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", o_rk_idx); end
    checks++; if (o_rk_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", o_rk_last); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [127:0] keys [0:1];
    logic [127:0] k1 [0:1];
    logic [127:0] k10 [0:1];
    exp_t e;
    int first_cyc;
    int last_cyc;
    keys[0] = KEY_FIPS;
    k1[0]   = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    k10[0]  = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    keys[1] = KEY_ZERO;
    k1[1]   = 128'h62636363_62636363_62636363_62636363;
    k10[1]  = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
    for (int v = 0; v < 2; v++) begin
      first_cyc = -1;
      last_cyc  = -1;
      push_stream(keys[v]);
      i_rk_rdy = 1'b1;
      send_key(keys[v]);
      for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
        if (o_rk_vld) begin
          e = sb.pop_front();
          checks++; if (o_rk !== e.rk || o_rk_idx !== e.idx) begin failures++; $display("FAIL vec%0d_rk got=%h/%0d exp=%h/%0d", v, o_rk, o_rk_idx, e.rk, e.idx); end
          checks++; if (o_rk_last !== (e.idx == 4'd10)) begin failures++; $display("FAIL vec%0d_last idx=%0d got=%0b", v, e.idx, o_rk_last); end
          if (e.idx == 4'd1) begin
            checks++; if (o_rk !== k1[v]) begin failures++; $display("FAIL vec%0d_idx1 got=%h exp=%h", v, o_rk, k1[v]); end
          end
          if (e.idx == 4'd0) first_cyc = cyc;
          if (e.idx == 4'd10) begin
            last_cyc = cyc;
            checks++; if (o_rk !== k10[v]) begin failures++; $display("FAIL vec%0d_idx10 got=%h exp=%h", v, o_rk, k10[v]); end
          end
        end
        @(negedge clk);
      end
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL vec%0d_timeout left=%0d exp=0", v, sb.size()); sb.delete(); end
      checks++; if (last_cyc - first_cyc != 10) begin failures++; $display("FAIL vec%0d_throughput span=%0d exp=10", v, last_cyc - first_cyc); end
      checks++; if (o_rk_vld !== 1'b0 || o_key_rdy !== 1'b1) begin failures++; $display("FAIL vec%0d_end vld=%0b rdy=%0b exp=0/1", v, o_rk_vld, o_key_rdy); end
      checks++; if (o_rk !== k10[v]) begin failures++; $display("FAIL vec%0d_retain got=%h exp=%h", v, o_rk, k10[v]); end
      last_key = keys[v];
    end
  endtask

  task automatic test_stall();
    exp_t e;
    logic [127:0] held;
    logic [3:0]   held_idx;
    logic         was_stall;
    was_stall = 1'b0;
    held      = '0;
    held_idx  = '0;
    push_stream(KEY_FIPS);
    i_rk_rdy = 1'b0;
    send_key(KEY_FIPS);
    for (int cyc = 0; cyc < 300 && sb.size() > 0; cyc++) begin
      if (was_stall) begin
        checks++; if (o_rk !== held || o_rk_idx !== held_idx || o_rk_vld !== 1'b1) begin failures++; $display("FAIL stall_hold got=%h/%0d exp=%h/%0d", o_rk, o_rk_idx, held, held_idx); end
      end
      i_rk_rdy  = ($urandom_range(0, 2) == 0);
      was_stall = o_rk_vld && !i_rk_rdy;
      held      = o_rk;
      held_idx  = o_rk_idx;
      if (o_rk_vld && i_rk_rdy) begin
        e = sb.pop_front();
        checks++; if (o_rk !== e.rk || o_rk_idx !== e.idx) begin failures++; $display("FAIL stall_rk got=%h/%0d exp=%h/%0d", o_rk, o_rk_idx, e.rk, e.idx); end
      end
      @(negedge clk);
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL stall_timeout left=%0d exp=0", sb.size()); sb.delete(); end
    i_rk_rdy = 1'b1;
    @(negedge clk);
    last_key = KEY_FIPS;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int pops;
    int gap;
    pops = 0;
    gap  = 0;
    push_stream(KEY_FIPS);
    push_stream(KEY_C1);
    i_rk_rdy = 1'b1;
    @(negedge clk);
    i_key     = KEY_FIPS;
    i_key_vld = 1'b1;
    @(negedge clk);
    i_key = KEY_C1;
    for (int cyc = 0; cyc < 80 && sb.size() > 0; cyc++) begin
      if (o_rk_vld) begin
        checks++; if (o_key_rdy !== 1'b0) begin failures++; $display("FAIL b2b_rdy_in_run got=%0b exp=0", o_key_rdy); end
        e = sb.pop_front();
        checks++; if (o_rk !== e.rk || o_rk_idx !== e.idx) begin failures++; $display("FAIL b2b_rk pop=%0d got=%h/%0d exp=%h/%0d", pops, o_rk, o_rk_idx, e.rk, e.idx); end
        if (pops == 11) i_key_vld = 1'b0;
        pops++;
      end else begin
        gap++;
      end
      @(negedge clk);
    end
    i_key_vld = 1'b0;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_timeout left=%0d exp=0", sb.size()); sb.delete(); end
    checks++; if (gap != 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=1", gap); end
    last_key = KEY_C1;
  endtask

  task automatic test_replay();
    int vld_cnt;
`ifdef AES_KEY_CACHE_EN
    exp_t e;
    push_stream(last_key);
    i_rk_rdy = 1'b1;
    @(negedge clk);
    i_replay = 1'b1;
    @(negedge clk);
    i_replay = 1'b0;
    for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
      if (o_rk_vld) begin
        e = sb.pop_front();
        checks++; if (o_rk !== e.rk || o_rk_idx !== e.idx) begin failures++; $display("FAIL replay_rk got=%h/%0d exp=%h/%0d", o_rk, o_rk_idx, e.rk, e.idx); end
      end
      @(negedge clk);
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL replay_timeout left=%0d exp=0", sb.size()); sb.delete(); end
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    i_replay = 1'b1;
    vld_cnt  = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_rk_vld) vld_cnt++;
    end
    i_replay = 1'b0;
    checks++; if (vld_cnt != 0) begin failures++; $display("FAIL replay_after_reset vld_cycles=%0d exp=0", vld_cnt); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic done;
    done = 1'b0;
    push_stream(KEY_FIPS);
    i_rk_rdy = 1'b1;
    send_key(KEY_FIPS);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (o_rk_vld) begin
        e = sb.pop_front();
        checks++; if (o_rk !== e.rk || o_rk_idx !== e.idx) begin failures++; $display("FAIL mid_rk got=%h/%0d exp=%h/%0d", o_rk, o_rk_idx, e.rk, e.idx); end
        if (o_rk_idx == 4'd4) done = 1'b1;
      end
      if (o_rk_vld && o_rk_idx == 4'd2) begin
        i_key     = ~KEY_FIPS;
        i_key_vld = 1'b1;
      end else begin
        i_key_vld = 1'b0;
      end
      @(negedge clk);
    end
    i_key_vld = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL mid_timeout idx4 not reached got=%0d", o_rk_idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_rk_vld !== 1'b0 || o_key_rdy !== 1'b1) begin failures++; $display("FAIL mid_async_reset vld=%0b rdy=%0b exp=0/1", o_rk_vld, o_key_rdy); end
    checks++; if (o_rk !== 128'h0 || o_rk_idx !== 4'd0) begin failures++; $display("FAIL mid_reset_rk got=%h/%0d exp=0/0", o_rk, o_rk_idx); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_stream(KEY_ZERO);
    send_key(KEY_ZERO);
    for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
      if (o_rk_vld) begin
        e = sb.pop_front();
        checks++; if (o_rk !== e.rk || o_rk_idx !== e.idx) begin failures++; $display("FAIL mid_restart_rk got=%h/%0d exp=%h/%0d", o_rk, o_rk_idx, e.rk, e.idx); end
      end
      @(negedge clk);
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_restart_timeout left=%0d exp=0", sb.size()); sb.delete(); end
  endtask

  initial begin
    last_key = KEY_ZERO;
    test_reset();
    test_vectors();
    test_stall();
    test_back_to_back();
    test_replay();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
